tx_arbiter: RTL

- Round-robin scheduler that shares one serial transmitter among NUM_REQ byte producers.
- Sits between the requesters and the transmitter's data_in/load/transmit_enable/character_sent interface.
- Sequences each character through arm, load, wait-for-sent and inter-character gap.
- Flags a transmitter that never reports completion.

---
 rtl/tx_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// Round-robin scheduler that shares one serial transmitter among NUM_REQ byte producers.
// Each character runs ARM -> LOAD -> WAIT_SENT -> GAP, with a watchdog on the completion flag.
module tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    last_grant,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         tx_data_in,
  output logic                          tx_load,
  output logic                          tx_transmit_enable,
  input  logic                          tx_character_sent,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] IDX_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    WAIT_SENT,
    GAP
  } state_t;

  state_t state;
  state_t state_next;

  logic [GAP_W-1:0]      gap_cnt;
  logic [GAP_W-1:0]      gap_cnt_next;
  logic [TO_W-1:0]       to_cnt;
  logic [TO_W-1:0]       to_cnt_next;
  logic                  seen_low;
  logic                  seen_low_next;

  logic [NUM_REQ-1:0]    grant_next;
  logic [IDX_W-1:0]      last_grant_next;
  logic                  busy_next;
  logic [DATA_WIDTH-1:0] tx_data_next;
  logic                  tx_load_next;
  logic                  tx_en_next;
  logic                  timeout_next;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic                  sent_done;
  logic                  to_expired;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_bytes[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search starts one past the previous winner; the IDX_W-bit add wraps because NUM_REQ is a power of two.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_valid && req[last_grant + IDX_W'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = last_grant + IDX_W'(i);
      end
    end
  end

  // A high flag only counts once a low has been seen, so a level left over from the last character is ignored.
  assign sent_done  = (state == WAIT_SENT) && tx_character_sent && seen_low;
  assign to_expired = (state == WAIT_SENT) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      gap_cnt            <= '0;
      to_cnt             <= '0;
      seen_low           <= 1'b0;
      grant              <= '0;
      last_grant         <= IDX_RESET;
      busy               <= 1'b0;
      tx_data_in         <= '0;
      tx_load            <= 1'b0;
      tx_transmit_enable <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      state              <= state_next;
      gap_cnt            <= gap_cnt_next;
      to_cnt             <= to_cnt_next;
      seen_low           <= seen_low_next;
      grant              <= grant_next;
      last_grant         <= last_grant_next;
      busy               <= busy_next;
      tx_data_in         <= tx_data_next;
      tx_load            <= tx_load_next;
      tx_transmit_enable <= tx_en_next;
      timeout_err        <= timeout_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_valid) state_next = ARM;
      ARM:       state_next = LOAD;
      LOAD:      state_next = WAIT_SENT;
      WAIT_SENT: if (sent_done || to_expired) state_next = GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, so every registered output lines up with that state.
  always_comb begin
    grant_next      = '0;
    last_grant_next = last_grant;
    busy_next       = (state_next != IDLE);
    tx_data_next    = tx_data_in;
    tx_load_next    = 1'b0;
    tx_en_next      = 1'b0;
    timeout_next    = 1'b0;
    gap_cnt_next    = gap_cnt;
    to_cnt_next     = to_cnt;
    seen_low_next   = seen_low;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_next[pick_idx] = 1'b1;
          last_grant_next      = pick_idx;
          tx_data_next         = req_bytes[pick_idx];
          tx_en_next           = 1'b1;
        end
      end
      ARM: begin
        tx_load_next = 1'b1;
        tx_en_next   = 1'b1;
      end
      LOAD: begin
        tx_en_next    = 1'b1;
        seen_low_next = 1'b0;
        to_cnt_next   = '0;
      end
      WAIT_SENT: begin
        if (!tx_character_sent) seen_low_next = 1'b1;
        if (sent_done) begin
          gap_cnt_next = '0;
        end else if (to_expired) begin
          timeout_next = 1'b1;
          gap_cnt_next = '0;
        end else begin
          tx_en_next  = 1'b1;
          to_cnt_next = to_cnt + 1'b1;
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt + 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
